dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

MEM-stage data-memory access controller, between the EX/MEM pipeline register and the MEM/WB pipeline register. Turns load/store control from EX/MEM into a req/ack transaction on the data-memory port and freezes the upstream pipeline until the access completes. Delivers the load result (`memdata_o`) and a bubble-safe write-back control (`wb_o`) to MEM/WB. MEM/WB has no enable, so this block squashes `wb_o` to 2'b00 during every stall cycle.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, maximum REQ cycles without ack (used only with `DMEM_TIMEOUT_EN`)

- `clk_i`  in  1  clock; all state changes on rising edge
- `rst_i`  in  1  reset; synchronous, active-high
- `memread_i`  in  1  load request from EX/MEM
- `memwrite_i`  in  1  store request from EX/MEM
- `addr_i`  in  ADDR_W  byte address (ALU result)
- `wdata_i`  in  DATA_W  store data
- `wb_i`  in  2  write-back control from EX/MEM
- `wb_o`  out  2  write-back control to MEM/WB; 2'b00 while `stall_o` or `misalign_o`
- `memdata_o`  out  DATA_W  last completed load data
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- `misalign_o`  out  1  access with `addr_i[1:0] != 0` (combinational)
- `timeout_o`  out  1  one-cycle pulse on an aborted access
- `dmem_req_o`  out  1  memory request
- `dmem_we_o`  out  1  1 = write
- `dmem_addr_o`  out  ADDR_W  registered address
- `dmem_wdata_o`  out  DATA_W  registered write data
- `dmem_rdata_i`  in  DATA_W  read data, valid with ack
- `dmem_ack_i`  in  1  transaction complete

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `access = (memread_i | memwrite_i) & aligned`. If `access` is high, latch addr, wdata and `we = memwrite_i`, then go to REQ. `memwrite_i` wins when both requests are set.
- REQ: `dmem_req_o = 1`. On `dmem_ack_i`, capture `dmem_rdata_i` into `memdata_o` (reads only) and go to DONE.
- DONE: hold for one cycle, then return to IDLE unconditionally. The request inputs are not re-sampled, because EX/MEM still holds the same instruction.
- `stall_o = (IDLE & access) | REQ`.
- `wb_o = (stall_o | misalign_o) ? 2'b00 : wb_i`.
- Misaligned access: no request, no stall, `misalign_o` high for that cycle, instruction squashed.
- `dmem_ack_i` is ignored in IDLE and DONE.
- `memdata_o` holds its value across writes and idle cycles.
- Reset values: state IDLE; `memdata_o`, `dmem_addr_o`, `dmem_wdata_o` all 0; `dmem_req_o`, `dmem_we_o`, `timeout_o` all 0.
- Reset mid-REQ: next edge enters IDLE and drops `dmem_req_o`. A late ack is ignored.

## Timing
- Zero-wait memory (ack in first REQ cycle): access spans 3 cycles (IDLE, REQ, DONE) with 2 stall cycles. MEM/WB captures real `wb`/`memdata` at the end of DONE.
- Each extra wait cycle adds one stall cycle.
- `dmem_addr_o`, `dmem_wdata_o` and `dmem_we_o` are stable for the whole REQ state.
- `stall_o` and `misalign_o` are combinational from the inputs and state; there is no registered delay.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop the request, go to DONE, set `memdata_o` to 0 for reads, and pulse `timeout_o` during the DONE cycle.
- `DMEM_TIMEOUT_EN` undefined: REQ waits indefinitely and `timeout_o` is tied to 0. The port stays present.

## Structure
- Shared package `cpu_pkg` holds the FSM state encoding (2 bits), the `WB_W = 2` constant and the `WB_NOP = 2'b00` constant.
- One sub-module, `dmem_timeout_ctr` (enable, clear, terminal-count output), instantiated only under `DMEM_TIMEOUT_EN`.

## Test plan
- Load, `addr_i = 0x10`, ack on first REQ cycle, rdata `0xCAFEF00D`:
  - `stall_o` high for 2 cycles and `wb_o = 00` during them.
  - DONE: `memdata_o = 0xCAFEF00D`, `wb_o = wb_i`.
- Store, `addr_i = 0x20`, `wdata_i = 0x12345678`, ack after 3 wait cycles:
  - `dmem_we_o = 1` and addr/wdata stable through REQ.
  - 5 stall cycles; `memdata_o` unchanged.
- Load, `addr_i = 0x13`: `misalign_o = 1` for 1 cycle, no `dmem_req_o`, `stall_o = 0`, `wb_o = 00`.
- `rst_i` asserted in the 2nd REQ cycle, ack 2 cycles later: state returns to IDLE, `dmem_req_o = 0`, and the late ack does not change `memdata_o`.
- `DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES = 4`, no ack: request drops after 4 REQ cycles, `timeout_o` pulses 1 cycle, `memdata_o = 0`, stall released.
- `memread_i` and `memwrite_i` both high, ack immediate: a write is issued and `memdata_o` is unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM encoding and write-back control constants.
package cpu_pkg;

  localparam int WB_W = 2;
  localparam logic [WB_W-1:0] WB_NOP = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Wait-cycle counter for the data-memory request; tc_o flags the last allowed REQ cycle.
module dmem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  // Counting stops at the terminal value so the counter never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller: req/ack handshake, pipeline stall, bubble-safe wb.
// Optional request timeout is enabled by defining DMEM_TIMEOUT_EN.
import cpu_pkg::*;

module dmem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [WB_W-1:0]   wb_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [DATA_W-1:0] memdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              timeout_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i
);

  dmem_state_e       state_q;
  logic [DATA_W-1:0] memdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_q;
  logic              we_q;
  logic              timeout_q;

  logic request;
  logic aligned;
  logic access;
  logic in_idle;
  logic in_req;
  logic timeout_hit;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign request = memread_i | memwrite_i;
  assign aligned = is_word_aligned(addr_i[1:0]);
  assign access  = request & aligned;

  // Misaligned instructions are squashed without touching memory or the pipeline.
  assign misalign_o = in_idle & request & ~aligned;
  assign stall_o    = (in_idle & access) | in_req;
  assign wb_o       = (stall_o | misalign_o) ? WB_NOP : wb_i;

`ifdef DMEM_TIMEOUT_EN
  logic ctr_tc;

  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~in_req),
    .en_i  (in_req & ~dmem_ack_i),
    .tc_o  (ctr_tc)
  );

  assign timeout_hit = in_req & ~dmem_ack_i & ctr_tc;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // DONE does not re-sample the request inputs: EX/MEM still holds the finished instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      memdata_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= memwrite_i;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_ack_i) begin
            if (!we_q) begin
              memdata_q <= dmem_rdata_i;
            end
            req_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            if (!we_q) begin
              memdata_q <= '0;
            end
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign memdata_o    = memdata_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed, table-driven bench for dmem_access_unit; timeout sequence runs when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_unit;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_CYCLES = 4;
`else
  localparam int TO_CYCLES = 255;
`endif

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  wbIn;
  logic [1:0]  wbOut;
  logic [31:0] memdata;
  logic        stall;
  logic        misalign;
  logic        timeout;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [31:0] dmemRdata;
  logic        dmemAck;

  int checks;
  int failures;

  dmem_access_unit #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .memread_i    (memread),
    .memwrite_i   (memwrite),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .wb_i         (wbIn),
    .wb_o         (wbOut),
    .memdata_o    (memdata),
    .stall_o      (stall),
    .misalign_o   (misalign),
    .timeout_o    (timeout),
    .dmem_req_o   (dmemReq),
    .dmem_we_o    (dmemWe),
    .dmem_addr_o  (dmemAddr),
    .dmem_wdata_o (dmemWdata),
    .dmem_rdata_i (dmemRdata),
    .dmem_ack_i   (dmemAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  wb;
    logic        expStall;
    logic        expMisalign;
    logic [1:0]  expWb;
  } vector_t;

  vector_t vectors [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] wb);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    wbIn     = wb;
  endtask

  // Called just after a rising edge with an access already driven; returns at the
  // falling edge of the first non-stalled cycle (DONE).
  task automatic runAccess(input int ackAfter, input logic [31:0] rdata, input logic expWe,
                           input logic [31:0] expAddr, input logic [31:0] expWdata,
                           output int stalls);
    int  reqs;
    bit  done;
    stalls = 0;
    reqs   = 0;
    done   = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1;
      if (dmemReq) begin
        reqs++;
        checkOutput("reqWe", dmemWe, expWe);
        checkOutput("reqAddr", dmemAddr, expAddr);
        checkOutput("reqWdata", dmemWdata, expWdata);
        if (reqs == ackAfter + 1) begin
          dmemAck   = 1'b1;
          dmemRdata = rdata;
        end
      end
      if (!done) begin
        @(posedge clk);
        #1;
        dmemAck = 1'b0;
      end
    end
    checkOutput("accessCompletes", done, 1);
  endtask

  task automatic idleNextCycle();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
  endtask

  initial begin
    int stalls;
    checks    = 0;
    failures  = 0;
    dmemAck   = 1'b0;
    dmemRdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rstMemdata", memdata, 32'h0);
    checkOutput("rstReq", dmemReq, 0);
    checkOutput("rstWe", dmemWe, 0);
    checkOutput("rstAddr", dmemAddr, 32'h0);
    checkOutput("rstWdata", dmemWdata, 32'h0);
    checkOutput("rstTimeout", timeout, 0);
    checkOutput("rstStall", stall, 0);
    checkOutput("rstWb", wbOut, 2'b10);

    vectors[0] = '{1'b0, 1'b0, 32'h0000_0010, 2'b10, 1'b0, 1'b0, 2'b10};
    vectors[1] = '{1'b1, 1'b0, 32'h0000_0010, 2'b11, 1'b1, 1'b0, 2'b00};
    vectors[2] = '{1'b0, 1'b1, 32'h0000_0024, 2'b01, 1'b1, 1'b0, 2'b00};
    vectors[3] = '{1'b1, 1'b0, 32'h0000_0013, 2'b11, 1'b0, 1'b1, 2'b00};
    vectors[4] = '{1'b0, 1'b1, 32'h0000_0022, 2'b01, 1'b0, 1'b1, 2'b00};
    vectors[5] = '{1'b0, 1'b0, 32'h0000_0013, 2'b01, 1'b0, 1'b0, 2'b01};
    vectors[6] = '{1'b1, 1'b1, 32'h0000_0101, 2'b11, 1'b0, 1'b1, 2'b00};
    vectors[7] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 2'b10, 1'b1, 1'b0, 2'b00};

    // Vectors are removed before the next rising edge so the FSM stays in IDLE.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vectors[i].rd, vectors[i].wr, vectors[i].addr, 32'h0, vectors[i].wb);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.stall", i), stall, vectors[i].expStall);
      checkOutput($sformatf("vec%0d.misalign", i), misalign, vectors[i].expMisalign);
      checkOutput($sformatf("vec%0d.wb", i), wbOut, vectors[i].expWb);
      checkOutput($sformatf("vec%0d.req", i), dmemReq, 0);
      #1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    end

    $display("[TB] zero-wait load");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2'b11);
    runAccess(0, 32'hCAFE_F00D, 1'b0, 32'h10, 32'h0, stalls);
    checkOutput("loadStalls", stalls, 2);
    checkOutput("loadMemdata", memdata, 32'hCAFE_F00D);
    checkOutput("loadDoneWb", wbOut, 2'b11);
    checkOutput("loadDoneReq", dmemReq, 0);
    idleNextCycle();

    $display("[TB] store with three wait cycles");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h1234_5678, 2'b01);
    runAccess(3, 32'hBAD0_BAD0, 1'b1, 32'h20, 32'h1234_5678, stalls);
    checkOutput("storeStalls", stalls, 5);
    checkOutput("storeMemdata", memdata, 32'hCAFE_F00D);
    checkOutput("storeDoneWb", wbOut, 2'b01);
    idleNextCycle();

    $display("[TB] read and write together");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 32'h44, 32'hA5A5_0F0F, 2'b11);
    runAccess(0, 32'h1111_2222, 1'b1, 32'h44, 32'hA5A5_0F0F, stalls);
    checkOutput("bothStalls", stalls, 2);
    checkOutput("bothMemdata", memdata, 32'hCAFE_F00D);
    idleNextCycle();

    $display("[TB] misaligned load");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 2'b11);
    @(negedge clk);
    checkOutput("misMisalign", misalign, 1);
    checkOutput("misStall", stall, 0);
    checkOutput("misWb", wbOut, 2'b00);
    checkOutput("misReq", dmemReq, 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    @(negedge clk);
    checkOutput("misReqAfter", dmemReq, 0);
    checkOutput("misMisalignAfter", misalign, 0);
    checkOutput("misMemdata", memdata, 32'hCAFE_F00D);

`ifdef DMEM_TIMEOUT_EN
    $display("[TB] load timeout");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 2'b11);
    runAccess(1000, 32'h0, 1'b0, 32'h30, 32'h0, stalls);
    checkOutput("toStalls", stalls, 5);
    checkOutput("toPulse", timeout, 1);
    checkOutput("toMemdata", memdata, 32'h0);
    checkOutput("toReq", dmemReq, 0);
    idleNextCycle();
    @(negedge clk);
    checkOutput("toPulseEnds", timeout, 0);
    checkOutput("toStallReleased", stall, 0);
`endif

    $display("[TB] reset during REQ with late ack");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'b11);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidReqBefore", dmemReq, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    @(negedge clk);
    checkOutput("rstMidReqDrop", dmemReq, 0);
    checkOutput("rstMidStall", stall, 0);
    @(posedge clk);
    #1;
    dmemAck   = 1'b1;
    dmemRdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    dmemAck = 1'b0;
    @(negedge clk);
    checkOutput("lateAckMemdata", memdata, 32'h0);
    checkOutput("lateAckReq", dmemReq, 0);
    checkOutput("lateAckStall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
